// File: rtl/alu_pkg.sv
// Shared definitions for the ALU scheduler slice: opcodes and FSM states.
package alu_pkg;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/alu_4bit.sv
// Combinational 4-bit ALU producing a 5-bit {carry, result}.
module alu_4bit
  import alu_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic [2:0] op,
  output logic [3:0] result,
  output logic       carry
);

  logic [4:0] sum;

  // Evaluate the selected operation; unused opcodes answer zero.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    sum = '0;
    case (op)
      ALU_ADD: sum = {1'b0, a} + {1'b0, b};
      ALU_SUB: sum = {1'b0, a} - {1'b0, b};  // bit 4 set means borrow (a < b)
      ALU_AND: sum = {1'b0, a & b};
      ALU_OR:  sum = {1'b0, a | b};
      ALU_XOR: sum = {1'b0, a ^ b};
      default: sum = '0;
    endcase
  end

  assign {carry, result} = sum;

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: the search starts one past rr_ptr and wraps around.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  rr_ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  grant_idx
);

  // Pick the first asserted request after the pointer position.
  always_comb begin
    int  idx;
    logic found;
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(rr_ptr) + k) % NREQ;
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = IDW'(idx);
      end
    end
  end

endmodule

// File: rtl/alu_rr_scheduler.sv
// Shares one alu_4bit between NREQ requesters: round-robin accept in IDLE,
// one-cycle execute, then hold the tagged result until the consumer takes it.
module alu_rr_scheduler
  import alu_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*4-1:0] req_a,
  input  logic [NREQ*4-1:0] req_b,
  input  logic [NREQ*3-1:0] req_op,
  output logic [NREQ-1:0]   req_ready,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [3:0]        rsp_result,
  output logic              rsp_carry,
  output logic              busy
);

  state_t           state, state_d;
  logic [IDW-1:0]   rr_ptr;
  logic [NREQ-1:0]  grant;
  logic [IDW-1:0]   grant_idx;
  logic [3:0]       a_q, b_q;
  logic [2:0]       op_q;
  logic [IDW-1:0]   id_q;
  logic [3:0]       sel_a, sel_b;
  logic [2:0]       sel_op;
  logic [3:0]       alu_result;
  logic             alu_carry;
  logic             accept;
  logic             rsp_done;

  rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
    .req       (req_valid),
    .rr_ptr    (rr_ptr),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  alu_4bit u_alu (
    .a      (a_q),
    .b      (b_q),
    .op     (op_q),
    .result (alu_result),
    .carry  (alu_carry)
  );

  assign accept    = (state == ST_IDLE) && (|req_valid);
  assign rsp_done  = (state == ST_RESP) && rsp_ready;
  assign req_ready = (state == ST_IDLE) ? grant : '0;
  assign busy      = (state != ST_IDLE);

  // Route the winning requester's operands to the operand registers.
  always_comb begin
    sel_a  = req_a[int'(grant_idx)*4 +: 4];
    sel_b  = req_b[int'(grant_idx)*4 +: 4];
    sel_op = req_op[int'(grant_idx)*3 +: 3];
  end

  // Next-state logic: IDLE -> EXEC on accept, EXEC -> RESP always, RESP -> IDLE on handshake.
  always_comb begin
    state_d = state;
    case (state)
      ST_IDLE: if (accept) state_d = ST_EXEC;
      ST_EXEC: state_d = ST_RESP;
      ST_RESP: if (rsp_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_d;
  end

  // Operand capture, response registers and round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: all registers use non-blocking assignments and are reset, including operand holders, so no X ever reaches the ALU.
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= '0;
      id_q       <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= '0;
      rsp_result <= '0;
      rsp_carry  <= 1'b0;
      rr_ptr     <= IDW'(NREQ - 1);
    end else begin
      if (accept) begin
        a_q  <= sel_a;
        b_q  <= sel_b;
        op_q <= sel_op;
        id_q <= grant_idx;
      end
      if (state == ST_EXEC) begin
        rsp_valid  <= 1'b1;
        rsp_id     <= id_q;
        rsp_result <= alu_result;
        rsp_carry  <= alu_carry;
      end
      if (rsp_done) begin
        rsp_valid <= 1'b0;
        rr_ptr    <= rsp_id;
      end
    end
  end

endmodule

// File: tb/tb_alu_rr_scheduler.sv
// Self-checking bench for alu_rr_scheduler with a behavioural arbitration/ALU model.
module tb_alu_rr_scheduler;

  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic              clk;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*4-1:0] req_a;
  logic [NREQ*4-1:0] req_b;
  logic [NREQ*3-1:0] req_op;
  logic [NREQ-1:0]   req_ready;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [IDW-1:0]    rsp_id;
  logic [3:0]        rsp_result;
  logic              rsp_carry;
  logic              busy;

  int n_checks = 0;
  int n_fail   = 0;
  int ptr      = NREQ - 1;  // model of the requester that was served last

  alu_rr_scheduler #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_op     (req_op),
    .req_ready  (req_ready),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
    .rsp_carry  (rsp_carry),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic int exp_winner(input logic [NREQ-1:0] v);
    for (int k = 1; k <= NREQ; k++)
      if (v[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
    return -1;
  endfunction

  function automatic logic [4:0] exp_alu(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op);
    int ai = int'(a);
    int bi = int'(b);
    case (op)
      3'd0: return 5'(ai + bi);
      3'd1: return {(ai < bi) ? 1'b1 : 1'b0, 4'((ai - bi + 16) % 16)};
      3'd2: return {1'b0, a & b};
      3'd3: return {1'b0, a | b};
      3'd4: return {1'b0, a ^ b};
      default: return 5'd0;
    endcase
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic set_req(input int i, input logic [3:0] a, input logic [3:0] b, input logic [2:0] op);
    req_a[4*i +: 4]  = a;
    req_b[4*i +: 4]  = b;
    req_op[3*i +: 3] = op;
    req_valid[i]     = 1'b1;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    ptr   = NREQ - 1;
    @(posedge clk); #1;
  endtask

  // Runs one transaction from IDLE with rsp_ready high and reports what the DUT did.
  task automatic run_op(input bit drop,
                        output logic [NREQ-1:0] g, output logic [NREQ-1:0] exp_g,
                        output int exp_id, output logic [4:0] exp_rsp,
                        output logic [IDW-1:0] id, output logic [4:0] rsp,
                        output int lat, output bit viol, output bit to);
    exp_id  = exp_winner(req_valid);
    exp_g   = '0;
    exp_rsp = '0;
    if (exp_id >= 0) begin
      exp_g[exp_id] = 1'b1;
      exp_rsp = exp_alu(req_a[4*exp_id +: 4], req_b[4*exp_id +: 4], req_op[3*exp_id +: 3]);
    end
    @(negedge clk);
    g = req_ready;
    @(posedge clk); #1;
    if (drop && exp_id >= 0) req_valid[exp_id] = 1'b0;
    lat = 0; viol = 1'b0; to = 1'b1; rsp = '0; id = '0;
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      if (req_ready !== '0) viol = 1'b1;
      if (rsp_valid === 1'b1) begin
        lat = n; to = 1'b0; id = rsp_id; rsp = {rsp_carry, rsp_result};
        break;
      end
    end
    @(posedge clk); #1;
    if (exp_id >= 0) ptr = exp_id;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0; req_valid = '0; req_a = '0; req_b = '0; req_op = '0; rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({req_ready, rsp_valid, rsp_id, rsp_result, rsp_carry, busy} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got ready=%b valid=%b id=%0d res=%h c=%b busy=%b, expected all zero",
               req_ready, rsp_valid, rsp_id, rsp_result, rsp_carry, busy);
    end
    rst_n = 1'b1;
    ptr   = NREQ - 1;
    @(posedge clk); #1;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || req_ready !== '0) begin
      n_fail++;
      $display("FAIL reset_idle: got busy=%b ready=%b expected 0/0000", busy, req_ready);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_basic_add();
    logic [NREQ-1:0] g, eg; int eid; logic [4:0] ersp, rsp; logic [IDW-1:0] id; int lat; bit viol, to;
    set_req(0, 4'd9, 4'd8, 3'b000);
    run_op(1'b1, g, eg, eid, ersp, id, rsp, lat, viol, to);
    n_checks++;
    if (g !== 4'b0001) begin n_fail++; $display("FAIL add_grant: got %b expected 0001", g); end
    n_checks++;
    if (to || lat != 2) begin n_fail++; $display("FAIL add_latency: got %0d (timeout=%0d) expected 2", lat, to); end
    n_checks++;
    if (id !== 2'd0 || rsp !== 5'b10001) begin
      n_fail++; $display("FAIL add_result: got id=%0d {c,r}=%b expected id=0 10001", id, rsp);
    end
    n_checks++;
    if (viol) begin n_fail++; $display("FAIL add_no_ready: got req_ready during EXEC/RESP expected none"); end
  endtask

  task automatic test_round_robin();
    logic [NREQ-1:0] g, eg; int eid; logic [4:0] ersp, rsp; logic [IDW-1:0] id; int lat; bit viol, to;
    int order[5] = '{0, 1, 2, 3, 0};
    do_reset();
    for (int i = 0; i < NREQ; i++) set_req(i, 4'(i + 1), 4'(2 * i), 3'(i));
    for (int k = 0; k < 5; k++) begin
      run_op(1'b0, g, eg, eid, ersp, id, rsp, lat, viol, to);
      n_checks++;
      if (g !== eg || eid != order[k]) begin
        n_fail++; $display("FAIL rr_grant[%0d]: got %b expected %b (requester %0d)", k, g, eg, order[k]);
      end
      n_checks++;
      if (to || int'(id) != order[k] || rsp !== ersp) begin
        n_fail++; $display("FAIL rr_rsp[%0d]: got id=%0d rsp=%b expected id=%0d rsp=%b", k, id, rsp, order[k], ersp);
      end
      n_checks++;
      if (viol) begin n_fail++; $display("FAIL rr_no_ready[%0d]: got req_ready during EXEC/RESP expected none", k); end
    end
    req_valid = '0;
  endtask

  task automatic test_sub();
    logic [NREQ-1:0] g, eg; int eid; logic [4:0] ersp, rsp; logic [IDW-1:0] id; int lat; bit viol, to;
    set_req(2, 4'd3, 4'd5, 3'b001);
    run_op(1'b1, g, eg, eid, ersp, id, rsp, lat, viol, to);
    n_checks++;
    if (to || id !== 2'd2 || rsp !== 5'b11110) begin
      n_fail++; $display("FAIL sub_borrow: got id=%0d {c,r}=%b expected id=2 11110", id, rsp);
    end
    set_req(2, 4'd5, 4'd3, 3'b001);
    run_op(1'b1, g, eg, eid, ersp, id, rsp, lat, viol, to);
    n_checks++;
    if (to || id !== 2'd2 || rsp !== 5'b00010) begin
      n_fail++; $display("FAIL sub_plain: got id=%0d {c,r}=%b expected id=2 00010", id, rsp);
    end
  endtask

  task automatic test_backpressure();
    logic [NREQ-1:0] g, eg; int eid; logic [4:0] ersp, rsp; logic [IDW-1:0] id; int lat; bit viol, to;
    logic [NREQ-1:0] exp1;
    logic [4:0] exp_r;
    logic [IDW-1:0] id0; logic [4:0] r0;
    int w; bit seen;
    rsp_ready = 1'b0;
    set_req(1, 4'd7, 4'd6, 3'b000);
    set_req(3, 4'd2, 4'd2, 3'b100);
    w = exp_winner(req_valid);
    exp1 = '0; exp1[w] = 1'b1;
    exp_r = exp_alu(req_a[4*w +: 4], req_b[4*w +: 4], req_op[3*w +: 3]);
    @(negedge clk);
    n_checks++;
    if (req_ready !== exp1) begin n_fail++; $display("FAIL bp_grant: got %b expected %b", req_ready, exp1); end
    @(posedge clk); #1;
    req_valid[w] = 1'b0;
    seen = 1'b0;
    for (int n = 0; n < 4 && !seen; n++) begin
      @(negedge clk);
      if (rsp_valid === 1'b1) seen = 1'b1;
    end
    id0 = rsp_id; r0 = {rsp_carry, rsp_result};
    n_checks++;
    if (!seen || int'(id0) != w || r0 !== exp_r) begin
      n_fail++; $display("FAIL bp_first: got seen=%0d id=%0d rsp=%b expected id=%0d rsp=%b", seen, id0, r0, w, exp_r);
    end
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      n_checks++;
      if (rsp_valid !== 1'b1 || rsp_id !== id0 || {rsp_carry, rsp_result} !== r0 || req_ready !== '0) begin
        n_fail++; $display("FAIL bp_hold[%0d]: got valid=%b id=%0d rsp=%b ready=%b expected 1/%0d/%b/0000",
                           n, rsp_valid, rsp_id, {rsp_carry, rsp_result}, req_ready, id0, r0);
      end
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    ptr = w;
    n_checks++;
    if (busy !== 1'b0 || rsp_valid !== 1'b0) begin
      n_fail++; $display("FAIL bp_release: got busy=%b valid=%b expected 0/0", busy, rsp_valid);
    end
    run_op(1'b1, g, eg, eid, ersp, id, rsp, lat, viol, to);
    n_checks++;
    if (g !== eg || to || int'(id) != eid || rsp !== ersp) begin
      n_fail++; $display("FAIL bp_next: got grant=%b id=%0d rsp=%b expected grant=%b id=%0d rsp=%b", g, id, rsp, eg, eid, ersp);
    end
    req_valid = '0;
  endtask

  task automatic test_logic();
    logic [NREQ-1:0] g, eg; int eid; logic [4:0] ersp, rsp; logic [IDW-1:0] id; int lat; bit viol, to;
    logic [2:0] ops[4]  = '{3'b010, 3'b011, 3'b100, 3'b111};
    logic [4:0] want[4] = '{5'b00010, 5'b00111, 5'b00101, 5'b00000};
    for (int k = 0; k < 4; k++) begin
      set_req(0, 4'd6, 4'd3, ops[k]);
      run_op(1'b1, g, eg, eid, ersp, id, rsp, lat, viol, to);
      n_checks++;
      if (to || id !== 2'd0 || rsp !== want[k]) begin
        n_fail++; $display("FAIL logic_op%b: got id=%0d {c,r}=%b expected id=0 %b", ops[k], id, rsp, want[k]);
      end
    end
  endtask

  task automatic test_random();
    logic [NREQ-1:0] g, eg; int eid; logic [4:0] ersp, rsp; logic [IDW-1:0] id; int lat; bit viol, to;
    for (int k = 0; k < 40; k++) begin
      req_valid = NREQ'($urandom_range(0, (1 << NREQ) - 1));
      req_a     = 16'($urandom());
      req_b     = 16'($urandom());
      req_op    = 12'($urandom());
      if (req_valid == '0) begin
        @(negedge clk);
        n_checks++;
        if (req_ready !== '0 || busy !== 1'b0) begin
          n_fail++; $display("FAIL rand_idle[%0d]: got ready=%b busy=%b expected 0000/0", k, req_ready, busy);
        end
        @(posedge clk); #1;
      end else begin
        run_op(1'b1, g, eg, eid, ersp, id, rsp, lat, viol, to);
        n_checks++;
        if (g !== eg || to || lat != 2 || viol || int'(id) != eid || rsp !== ersp) begin
          n_fail++;
          $display("FAIL rand_op[%0d]: got grant=%b id=%0d rsp=%b lat=%0d viol=%0d, expected grant=%b id=%0d rsp=%b lat=2",
                   k, g, id, rsp, lat, viol, eg, eid, ersp);
        end
      end
    end
    req_valid = '0;
  endtask

  task automatic test_reset_mid();
    logic [NREQ-1:0] g, eg; int eid; logic [4:0] ersp, rsp; logic [IDW-1:0] id; int lat; bit viol, to;
    set_req(3, 4'd9, 4'd8, 3'b000);
    run_op(1'b1, g, eg, eid, ersp, id, rsp, lat, viol, to);
    n_checks++;
    if (to || id !== 2'd3 || rsp !== 5'b10001) begin
      n_fail++; $display("FAIL mid_setup: got id=%0d rsp=%b expected id=3 10001", id, rsp);
    end
    set_req(0, 4'd7, 4'd7, 3'b000);
    @(posedge clk); #1;          // handshake done, DUT now in EXEC
    req_valid = '0;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({req_ready, rsp_valid, rsp_id, rsp_result, rsp_carry, busy} !== '0) begin
      n_fail++; $display("FAIL mid_reset_values: got ready=%b valid=%b id=%0d res=%h c=%b busy=%b expected all zero",
                         req_ready, rsp_valid, rsp_id, rsp_result, rsp_carry, busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    ptr = NREQ - 1;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      n_checks++;
      if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
        n_fail++; $display("FAIL mid_no_rsp[%0d]: got valid=%b busy=%b expected 0/0", n, rsp_valid, busy);
      end
    end
    @(posedge clk); #1;
    set_req(1, 4'd4, 4'd1, 3'b001);
    run_op(1'b1, g, eg, eid, ersp, id, rsp, lat, viol, to);
    n_checks++;
    if (g !== 4'b0010 || to || id !== 2'd1 || rsp !== 5'b00011) begin
      n_fail++; $display("FAIL mid_after: got grant=%b id=%0d rsp=%b expected 0010 id=1 00011", g, id, rsp);
    end
  endtask

  initial begin
    test_reset();
    test_basic_add();
    test_round_robin();
    test_sub();
    test_backpressure();
    test_logic();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
